// File: rtl/lcd_driver.sv
// lcd_driver: HD44780 8-bit write-only driver with autonomous power-on init and timed user writes
// Ports:
//    clk          system clock, rising edge
//    rst          synchronous active-high reset
//    go           level, starts initialisation while idle after reset
//    rs_in        register select of a user write (0 = command, 1 = data)
//    writeW       single-cycle user write request
//    db_in        byte of a user write
//    rs, en       LCD register select and enable strobe
//    db_out       LCD data bus
module lcd_driver #(
   parameter int unsigned T_POWERON = 416667,
   parameter int unsigned T_FS1     = 113889,
   parameter int unsigned T_FS2     = 2778,
   parameter int unsigned T_CMD     = 1112,
   parameter int unsigned T_CLEAR   = 45556,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_EN      = 14,
   parameter int unsigned T_HOLD    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       rs_in,
   input  logic       writeW,
   input  logic [7:0] db_in,
   output logic       rs,
   output logic       en,
   output logic [7:0] db_out
);
   typedef enum logic [2:0] {
      S_WAIT_GO, S_POWERON, S_SETUP, S_STROBE, S_HOLD, S_EXEC, S_READY
   } state_e;
   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, wait_q, wait_d;
   logic [2:0]  idx_q, idx_d;
   logic        init_q, init_d, rs_q, rs_d;
   logic        pend_q, pend_d, pend_rs_q, pend_rs_d;
   logic [7:0]  db_q, db_d, pend_db_q, pend_db_d;
   logic        done, take;

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      return (i == 3'd4) ? 8'h08 : (i == 3'd5) ? 8'h01 : (i == 3'd6) ? 8'h06 :
             (i == 3'd7) ? 8'h0C : 8'h38;
   endfunction

   function automatic logic [31:0] init_wait(input logic [2:0] i);
      return (i == 3'd0) ? T_FS1 : (i == 3'd1) ? T_FS2 : (i == 3'd5) ? T_CLEAR : T_CMD;
   endfunction

   // every timed state is loaded with its length minus one and left when the count hits zero
   assign done = (cnt_q == 32'd0);
   assign take = (state_q == S_READY) && (writeW || pend_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_WAIT_GO;
         cnt_q     <= '0;
         wait_q    <= '0;
         idx_q     <= '0;
         init_q    <= 1'b0;
         rs_q      <= 1'b0;
         db_q      <= '0;
         pend_q    <= 1'b0;
         pend_rs_q <= 1'b0;
         pend_db_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
         idx_q     <= idx_d;
         init_q    <= init_d;
         rs_q      <= rs_d;
         db_q      <= db_d;
         pend_q    <= pend_d;
         pend_rs_q <= pend_rs_d;
         pend_db_q <= pend_db_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT_GO: if (go) state_d = S_POWERON;
         S_POWERON: if (done) state_d = S_SETUP;
         S_SETUP:   if (done) state_d = S_STROBE;
         S_STROBE:  if (done) state_d = S_HOLD;
         S_HOLD:    if (done) state_d = S_EXEC;
         S_EXEC:    if (done) state_d = (init_q && idx_q != 3'd7) ? S_SETUP : S_READY;
         S_READY:   if (take) state_d = S_SETUP;
         default:   state_d = S_WAIT_GO;
      endcase
   end

   always_comb begin
      cnt_d     = done ? cnt_q : cnt_q - 32'd1;
      wait_d    = wait_q;
      idx_d     = idx_q;
      init_d    = init_q;
      rs_d      = rs_q;
      db_d      = db_q;
      pend_d    = pend_q;
      pend_rs_d = pend_rs_q;
      pend_db_d = pend_db_q;
      if (state_d != state_q)
         cnt_d = (state_d == S_POWERON) ? T_POWERON - 32'd1 :
                 (state_d == S_SETUP)   ? T_SETUP - 32'd1 :
                 (state_d == S_STROBE)  ? T_EN - 32'd1 :
                 (state_d == S_HOLD)    ? T_HOLD - 32'd1 :
                 (state_d == S_EXEC)    ? wait_q - 32'd1 : 32'd0;
      // requests while busy park in a single slot, newest wins; idle-before-go requests are dropped
      if (writeW && state_q != S_WAIT_GO && state_q != S_READY) begin
         pend_d    = 1'b1;
         pend_rs_d = rs_in;
         pend_db_d = db_in;
      end
      if (state_q == S_POWERON && done) begin
         init_d = 1'b1;
         idx_d  = 3'd0;
         rs_d   = 1'b0;
         db_d   = init_byte(3'd0);
         wait_d = init_wait(3'd0);
      end
      if (state_q == S_EXEC && done) begin
         if (init_q && idx_q != 3'd7) begin
            idx_d  = idx_q + 3'd1;
            db_d   = init_byte(idx_d);
            wait_d = init_wait(idx_d);
         end else begin
            init_d = 1'b0;
         end
      end
      // a fresh request in READY is newer than anything pending
      if (take) begin
         rs_d   = writeW ? rs_in : pend_rs_q;
         db_d   = writeW ? db_in : pend_db_q;
         pend_d = 1'b0;
         wait_d = (!rs_d && db_d inside {8'h01, 8'h02, 8'h03}) ? T_CLEAR : T_CMD;
      end
   end

   always_comb begin
      en     = (state_q == S_STROBE);
      rs     = rs_q;
      db_out = db_q;
   end
endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: scoreboard bench for lcd_driver with shortened timing parameters
module tb_lcd_driver;
   localparam int P = 300, FS1 = 120, FS2 = 60, CMD = 25, CLR = 90, S = 2, EN = 14, H = 2;

   logic       clk = 1'b0, rst = 1'b1, go = 1'b0, rs_in = 1'b0, writeW = 1'b0;
   logic [7:0] db_in = 8'h00;
   logic       rs, en;
   logic [7:0] db_out;

   lcd_driver #(
      .T_POWERON(P), .T_FS1(FS1), .T_FS2(FS2), .T_CMD(CMD),
      .T_CLEAR(CLR), .T_SETUP(S), .T_EN(EN), .T_HOLD(H)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .rs_in(rs_in), .writeW(writeW),
      .db_in(db_in), .rs(rs), .en(en), .db_out(db_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] db;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc = 0, nvec = 0, nmis = 0;
   logic       rst_e = 1'b1;
   logic [7:0] init_db [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
   int         init_w  [8] = '{FS1, FS2, CMD, CMD, CMD, CLR, CMD, CMD};

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_e <= rst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic r, input logic [7:0] d, input int c);
      exp_t e;
      e.rs  = r;
      e.db  = d;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int uw(input logic r, input logic [7:0] d);
      return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLR : CMD;
   endfunction

   task automatic push_init(input int g, output int last);
      int r;
      r = g + P + S;
      last = r;
      for (int i = 0; i < 8; i++) begin
         push(1'b0, init_db[i], r);
         last = r;
         r = r + EN + H + init_w[i] + S;
      end
   endtask

   task automatic wait_drain(input string tag, input int bound);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // issue A in READY, then B after gap cycles while A is still in flight
   task automatic user_pair(input logic ra, input logic [7:0] da, input logic rb,
                            input logic [7:0] db, input int gap);
      int ra_c;
      ra_c = cyc + 1 + S;
      push(ra, da, ra_c);
      push(rb, db, ra_c + EN + H + uw(ra, da) + 1 + S);
      writeW = 1'b1; rs_in = ra; db_in = da;
      tick(1);
      if (gap > 1) begin
         writeW = 1'b0;
         tick(gap - 1);
         writeW = 1'b1;
      end
      rs_in = rb; db_in = db;
      tick(1);
      writeW = 1'b0;
      wait_drain("pair_drain", 400);
      tick(EN + H + CLR + 10);
   endtask

   exp_t m;
   logic en_p = 1'b0;
   int   rise_c = -1;

   always @(negedge clk) begin
      if (rst_e) begin
         en_p   = 1'b0;
         rise_c = -1;
      end else begin
         if (en && !en_p) begin
            if (exp_q.size() == 0) begin
               chk("strobe_queued", 32'd0, 32'd1);
            end else begin
               m = exp_q.pop_front();
               chk("strobe_rs", 32'(rs), 32'(m.rs));
               chk("strobe_db", 32'(db_out), 32'(m.db));
               chk("strobe_cycle", 32'(cyc), 32'(m.cyc));
            end
            rise_c = cyc;
         end
         if (!en && en_p && rise_c >= 0) chk("en_width", 32'(cyc - rise_c), 32'(EN));
         en_p = en;
      end
   end

   initial begin
      int g, r7, k;
      tick(2);
      rst = 1'b0;
      chk("reset_bus", 32'({rs, en, db_out}), 32'd0);
      writeW = 1'b1; rs_in = 1'b1; db_in = 8'h77;
      tick(1);
      writeW = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         chk("idle_bus", 32'({rs, en, db_out}), 32'd0);
      end
      go = 1'b1;
      g = cyc + 1;
      push_init(g, r7);
      tick(10);
      writeW = 1'b1; rs_in = 1'b1; db_in = 8'h50;
      tick(1);
      writeW = 1'b0;
      tick(P + 50);
      writeW = 1'b1; rs_in = 1'b1; db_in = 8'h42;
      tick(1);
      writeW = 1'b0;
      push(1'b1, 8'h42, r7 + EN + H + CMD + 1 + S);
      wait_drain("init_drain", 3000);
      go = 1'b0;
      tick(EN + H + CLR + 10);
      user_pair(1'b1, 8'h35, 1'b1, 8'h36, 3);
      user_pair(1'b0, 8'h01, 1'b1, 8'h41, 3);
      user_pair(1'b0, 8'h03, 1'b0, 8'h02, 2);
      user_pair(1'b0, 8'h02, 1'b0, 8'h04, 1);
      user_pair(1'b1, 8'h01, 1'b0, 8'h00, 4);
      user_pair(1'b0, 8'h04, 1'b1, 8'h55, 3);
      push(1'b1, 8'h99, cyc + 1 + S);
      writeW = 1'b1; rs_in = 1'b1; db_in = 8'h99;
      tick(1);
      writeW = 1'b0;
      k = 0;
      while (!en && k < 20) begin
         tick(1);
         k++;
      end
      tick(5);
      chk("pre_reset_en", 32'(en), 32'd1);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_strobe", 32'({rs, en, db_out}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         chk("post_reset_idle", 32'({rs, en, db_out}), 32'd0);
      end
      chk("post_reset_queue", 32'(exp_q.size()), 32'd0);
      go = 1'b1;
      g = cyc + 1;
      push_init(g, r7);
      tick(1);
      go = 1'b0;
      wait_drain("reinit_drain", 3000);
      tick(EN + H + CMD + 5);
      chk("ready_retain", 32'({rs, en, db_out}), 32'h00C);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
